hilo_muldiv_ctrl: RTL and testbench

Multicycle controller that owns the HI/LO register pair for the MIPS CPU's DIV, DIVU, MULT, MULTU, MTHI and MTLO instructions.
- Divides iteratively, one restoring step per cycle, using the same {remainder, quotient} shift-register scheme as the team's divider.
- Applies MIPS sign rules to the quotient and remainder.
- Stalls the pipeline when MFHI/MFLO would read a stale HI/LO.
- Sits beside the ALU in the EX stage; the decode/hazard unit drives it.

---
 rtl/hilo_muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO owner for MIPS DIV/DIVU/MULT/MULTU/MTHI/MTLO with pipeline stall
// Optional build macro: DIVZERO_FAST_EN (divide by zero bypasses the iterative loop).
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_rd,
  output logic             req_ready,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_DIV   = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_MULTU = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DIV_FIX = 2'd2,
    S_MUL     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [2*WIDTH-1:0] r_acc;        // {remainder, quotient} for divide, {a, b} for multiply
  logic [WIDTH-1:0]   r_dvsr;
  logic [CW-1:0]      r_cnt;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_mul_signed;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_is_div;
  logic               w_is_mul;
  logic               w_sdiv;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_rem_ext;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_diff;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_mul_a;
  logic [WIDTH-1:0]   w_mul_b;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
`ifdef DIVZERO_FAST_EN
  logic               w_div_zero;
  assign w_div_zero = (rt_data == '0);
`endif

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_is_div = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign w_is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign w_sdiv   = (req_op == OP_DIV);

  // Signed divide works on magnitudes; signs are reapplied in DIV_FIX.
  assign w_rs_mag = (w_sdiv && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign w_rt_mag = (w_sdiv && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // The shifted remainder can need WIDTH+1 bits when the divisor is near full scale,
  // so the compare keeps the bit that falls out of the top of the register.
  assign w_rem_ext  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_ext >= {1'b0, r_dvsr});
  assign w_rem_diff = w_rem_ext[WIDTH-1:0] - r_dvsr;
  assign w_step     = w_ge ? {w_rem_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {w_rem_ext[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_mul_a  = r_acc[2*WIDTH-1:WIDTH];
  assign w_mul_b  = r_acc[WIDTH-1:0];
  assign w_prod_s = $signed({{WIDTH{w_mul_a[WIDTH-1]}}, w_mul_a}) *
                    $signed({{WIDTH{w_mul_b[WIDTH-1]}}, w_mul_b});
  assign w_prod_u = {{WIDTH{1'b0}}, w_mul_a} * {{WIDTH{1'b0}}, w_mul_b};

  assign w_q = r_acc[WIDTH-1:0];
  assign w_r = r_acc[2*WIDTH-1:WIDTH];

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state selection and handshake/stall outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    stall       = (r_state != S_IDLE) && (hilo_rd || req_valid);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_div) begin
`ifdef DIVZERO_FAST_EN
            w_state_nxt = w_div_zero ? S_DIV_FIX : S_DIV_RUN;
`else
            w_state_nxt = S_DIV_RUN;
`endif
          end else if (w_is_mul) begin
            w_state_nxt = S_MUL;
          end
        end
      end
      S_DIV_RUN: if (r_cnt == CNT_ONE) w_state_nxt = S_DIV_FIX;
      S_DIV_FIX: w_state_nxt = S_IDLE;
      S_MUL:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, divide iterations, and HI/LO/done updates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc        <= '0;
      r_dvsr       <= '0;
      r_cnt        <= '0;
      r_q_neg      <= 1'b0;
      r_r_neg      <= 1'b0;
      r_mul_signed <= 1'b0;
      r_done       <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_div) begin
              r_dvsr  <= w_rt_mag;
              r_q_neg <= w_sdiv && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              r_r_neg <= w_sdiv && rs_data[WIDTH-1];
              r_cnt   <= CNT_INIT;
              r_acc   <= {{WIDTH{1'b0}}, w_rs_mag};
`ifdef DIVZERO_FAST_EN
              // Preload what WIDTH iterations against a zero divisor would leave behind.
              if (w_div_zero) begin
                r_acc <= {w_rs_mag, {WIDTH{1'b1}}};
                r_cnt <= '0;
              end
`endif
            end else if (w_is_mul) begin
              r_acc        <= {rs_data, rt_data};
              r_mul_signed <= (req_op == OP_MULT);
            end else if (req_op == OP_MTHI) begin
              r_hi <= rs_data;
            end else if (req_op == OP_MTLO) begin
              r_lo <= rs_data;
            end
          end
        end
        S_DIV_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_DIV_FIX: begin
          r_lo   <= r_q_neg ? -w_q : w_q;
          r_hi   <= r_r_neg ? -w_r : w_r;
          r_done <= 1'b1;
        end
        S_MUL: begin
          {r_hi, r_lo} <= r_mul_signed ? w_prod_s : w_prod_u;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - randomized and directed self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hilo_rd;
  logic        req_ready;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  bit          fast = 1'b0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .hilo_rd   (hilo_rd),
    .req_ready (req_ready),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural reference: MIPS HI/LO results from plain arithmetic, plus latency.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 1;
    case (op)
      3'd1, 3'd2: begin
        lat = (fast && b == 32'h0) ? 2 : 34;
        if (b == 32'h0) begin
          m_hi = a;
          m_lo = (op == 3'd1 && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
        end else if (op == 3'd1) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd3: begin
        lat = 2;
        p = sa * sb;
        {m_hi, m_lo} = p;
      end
      3'd4: begin
        lat = 2;
        p = {32'h0, a} * {32'h0, b};
        {m_hi, m_lo} = p;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, follow it to completion, and check every cycle along the way.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rd);
    int lat;
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      step;
      n++;
    end
    chk($sformatf("op%0d_ready_before", op), req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    rs_data   = a;
    rt_data   = b;
    hilo_rd   = rd;
    model_op(op, a, b, lat);
    step;
    req_valid = 1'b0;
    req_op    = 3'd0;
    chk($sformatf("op%0d_done_e1", op), done, 0);
    if (lat == 1) begin
      chk($sformatf("op%0d_ready_e1", op), req_ready, 1);
      chk($sformatf("op%0d_hi", op), hi, m_hi);
      chk($sformatf("op%0d_lo", op), lo, m_lo);
    end else begin
      chk($sformatf("op%0d_busy_e1", op), busy, 1);
      for (int e = 2; e < lat; e++) begin
        step;
        chk($sformatf("op%0d_ready_e%0d", op, e), req_ready, 0);
        chk($sformatf("op%0d_done_e%0d", op, e), done, 0);
        chk($sformatf("op%0d_stall_e%0d", op, e), stall, {31'h0, rd});
      end
      step;
      chk($sformatf("op%0d_done_fin", op), done, 1);
      chk($sformatf("op%0d_ready_fin", op), req_ready, 1);
      chk($sformatf("op%0d_stall_fin", op), stall, 0);
      chk($sformatf("op%0d_hi a=%h b=%h", op, a, b), hi, m_hi);
      chk($sformatf("op%0d_lo a=%h b=%h", op, a, b), lo, m_lo);
    end
    hilo_rd = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
`ifdef DIVZERO_FAST_EN
    fast = 1'b1;
`endif
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    rs_data   = 32'h0;
    rt_data   = 32'h0;
    hilo_rd   = 1'b1;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    hilo_rd = 1'b0;
    reset   = 1'b1;
    step;

    do_op(3'd2, 32'd100, 32'd7, 1'b0);
    chk("divu100_7_lo", lo, 32'd14);
    chk("divu100_7_hi", hi, 32'd2);
    do_op(3'd1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    do_op(3'd1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    do_op(3'd4, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi", hi, 32'h1);
    do_op(3'd2, 32'd9, 32'd0, 1'b0);
    chk("divu_z_lo", lo, 32'hFFFF_FFFF);
    chk("divu_z_hi", hi, 32'd9);
    do_op(3'd1, 32'h8000_0005, 32'd0, 1'b0);
    do_op(3'd1, 32'd5, 32'd0, 1'b1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

    // DIVU 10/3 with MFxx waiting and an MTLO queued behind it.
    req_valid = 1'b1;
    req_op    = 3'd2;
    rs_data   = 32'd10;
    rt_data   = 32'd3;
    step;
    m_lo = 32'd3;
    m_hi = 32'd1;
    req_op  = 3'd6;
    rs_data = 32'd5;
    hilo_rd = 1'b1;
    for (int e = 2; e < 34; e++) begin
      step;
      chk($sformatf("hz_stall_e%0d", e), stall, 1);
      chk($sformatf("hz_lo_e%0d", e), lo, 32'd1);
    end
    step;
    chk("hz_stall_done", stall, 0);
    chk("hz_done", done, 1);
    chk("hz_lo", lo, 32'd3);
    chk("hz_hi", hi, 32'd1);
    hilo_rd = 1'b0;
    step;
    req_valid = 1'b0;
    req_op    = 3'd0;
    m_lo = 32'd5;
    chk("mtlo_after_lo", lo, 32'd5);
    chk("mtlo_after_hi", hi, 32'd1);
    chk("mtlo_after_done", done, 0);

    for (int i = 0; i < 24; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a divide.
    do_op(3'd5, 32'h0000_1234, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_op    = 3'd1;
    rs_data   = 32'd100;
    rt_data   = 32'd3;
    step;
    req_valid = 1'b0;
    req_op    = 3'd0;
    repeat (8) step;
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_done", done, 0);
    #3 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk($sformatf("post_rst_done%0d", k), done, 0);
      chk($sformatf("post_rst_busy%0d", k), busy, 0);
    end
    do_op(3'd2, 32'd8, 32'd2, 1'b0);
    chk("post_rst_lo", lo, 32'd4);
    chk("post_rst_hi", hi, 32'd0);
    step;
    chk("post_rst_done_clear", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
